// File: rtl/dataslot_cmd_arbiter.sv
// Round-robin arbiter sharing the APF target-dataslot command port between the MCU (r0) and a DMA engine (r1).
// Define DATASLOT_ARB_SYNC_EN to pass ack/done/err through 2-flop synchronizers before use.
module dataslot_cmd_arbiter #(
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        r0_req,
    input  logic        r0_write,
    input  logic [15:0] r0_id,
    input  logic [31:0] r0_slotoffset,
    input  logic [31:0] r0_bridgeaddr,
    input  logic [31:0] r0_length,
    output logic        r0_busy,
    output logic        r0_done,
    output logic [2:0]  r0_err,

    input  logic        r1_req,
    input  logic        r1_write,
    input  logic [15:0] r1_id,
    input  logic [31:0] r1_slotoffset,
    input  logic [31:0] r1_bridgeaddr,
    input  logic [31:0] r1_length,
    output logic        r1_busy,
    output logic        r1_done,
    output logic [2:0]  r1_err,

    output logic        target_dataslot_read,
    output logic        target_dataslot_write,
    output logic [15:0] target_dataslot_id,
    output logic [31:0] target_dataslot_slotoffset,
    output logic [31:0] target_dataslot_bridgeaddr,
    output logic [31:0] target_dataslot_length,
    input  logic        target_dataslot_ack,
    input  logic        target_dataslot_done,
    input  logic [2:0]  target_dataslot_err,

    output logic        owner,
    output logic        active
);

    localparam int PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_CYCLES - 1);
    localparam logic [2:0] ERR_TIMEOUT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_COMPLETE  = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic           ack_in;
    logic           done_in;
    logic [2:0]     err_in;

`ifdef DATASLOT_ARB_SYNC_EN
    logic [1:0] ack_sync_reg;
    logic [1:0] done_sync_reg;
    logic [2:0] err_sync0_reg;
    logic [2:0] err_sync1_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_sync_reg  <= '0;
            done_sync_reg <= '0;
            err_sync0_reg <= '0;
            err_sync1_reg <= '0;
        end else begin
            ack_sync_reg  <= {ack_sync_reg[0], target_dataslot_ack};
            done_sync_reg <= {done_sync_reg[0], target_dataslot_done};
            err_sync0_reg <= target_dataslot_err;
            err_sync1_reg <= err_sync0_reg;
        end
    end

    assign ack_in  = ack_sync_reg[1];
    assign done_in = done_sync_reg[1];
    assign err_in  = err_sync1_reg;
`else
    assign ack_in  = target_dataslot_ack;
    assign done_in = target_dataslot_done;
    assign err_in  = target_dataslot_err;
`endif

    // Requester parameters gathered into arrays so the grant can index them
    logic [1:0]  req_vec;
    logic [1:0]  write_vec;
    logic [15:0] id_vec   [2];
    logic [31:0] off_vec  [2];
    logic [31:0] addr_vec [2];
    logic [31:0] len_vec  [2];

    assign req_vec     = {r1_req, r0_req};
    assign write_vec   = {r1_write, r0_write};
    assign id_vec[0]   = r0_id;
    assign id_vec[1]   = r1_id;
    assign off_vec[0]  = r0_slotoffset;
    assign off_vec[1]  = r1_slotoffset;
    assign addr_vec[0] = r0_bridgeaddr;
    assign addr_vec[1] = r1_bridgeaddr;
    assign len_vec[0]  = r0_length;
    assign len_vec[1]  = r1_length;

    logic           owner_reg;
    logic           write_sel_reg;
    logic           last_grant_reg;
    logic           ack_seen_reg;
    logic [23:0]    tmo_cnt_reg;
    logic [PCW-1:0] pulse_cnt_reg;
    logic [15:0]    id_reg;
    logic [31:0]    off_reg;
    logic [31:0]    addr_reg;
    logic [31:0]    len_reg;

    logic [1:0]     pending;
    logic [2:0]     err_q [2];
    logic           grant;
    logic           timeout_hit;
    logic           err_load;
    logic [2:0]     err_load_val;
    logic [1:0]     done_vec;

    // Tie goes to whoever was not served last; otherwise the lone pending requester
    always_comb begin
        grant = 1'b0;
        if (pending == 2'b11) begin
            grant = ~last_grant_reg;
        end else if (pending[1]) begin
            grant = 1'b1;
        end
    end

    assign timeout_hit = (tmo_cnt_reg == TIMEOUT_CYCLES);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic       pending_reg;
            logic [2:0] err_reg;
            logic       mine;

            assign mine = (owner_reg == 1'(gi));

            // Completion clears before a new request can set, so a req in COMPLETE is dropped
            always_ff @(posedge clk) begin
                if (reset) begin
                    pending_reg <= 1'b0;
                    err_reg     <= 3'b000;
                end else begin
                    if (state_reg == S_COMPLETE && mine) begin
                        pending_reg <= 1'b0;
                    end else if (req_vec[gi]) begin
                        pending_reg <= 1'b1;
                    end
                    if (err_load && mine) begin
                        err_reg <= err_load_val;
                    end
                end
            end

            assign pending[gi] = pending_reg;
            assign err_q[gi]   = err_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        err_load     = 1'b0;
        err_load_val = 3'b000;
        case (state_reg)
            S_IDLE: begin
                if (|pending) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (timeout_hit) begin
                    state_next   = S_COMPLETE;
                    err_load     = 1'b1;
                    err_load_val = ERR_TIMEOUT;
                end else if (pulse_cnt_reg == PULSE_LAST) begin
                    state_next = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (timeout_hit) begin
                    state_next   = S_COMPLETE;
                    err_load     = 1'b1;
                    err_load_val = ERR_TIMEOUT;
                end else if (ack_seen_reg) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (timeout_hit) begin
                    state_next   = S_COMPLETE;
                    err_load     = 1'b1;
                    err_load_val = ERR_TIMEOUT;
                end else if (!ack_in && done_in) begin
                    state_next   = S_COMPLETE;
                    err_load     = 1'b1;
                    err_load_val = err_in;
                end
            end
            S_COMPLETE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_reg      <= 1'b0;
            write_sel_reg  <= 1'b0;
            last_grant_reg <= 1'b1;
            ack_seen_reg   <= 1'b0;
            tmo_cnt_reg    <= '0;
            pulse_cnt_reg  <= '0;
            id_reg         <= '0;
            off_reg        <= '0;
            addr_reg       <= '0;
            len_reg        <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (|pending) begin
                        owner_reg     <= grant;
                        write_sel_reg <= write_vec[grant];
                        id_reg        <= id_vec[grant];
                        off_reg       <= off_vec[grant];
                        addr_reg      <= addr_vec[grant];
                        len_reg       <= len_vec[grant];
                        tmo_cnt_reg   <= '0;
                        pulse_cnt_reg <= '0;
                        ack_seen_reg  <= 1'b0;
                    end
                end
                S_ISSUE, S_WAIT_ACK, S_WAIT_DONE: begin
                    tmo_cnt_reg  <= tmo_cnt_reg + 24'd1;
                    ack_seen_reg <= ack_seen_reg | ack_in;
                    if (state_reg == S_ISSUE) begin
                        pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
                    end
                end
                S_COMPLETE: begin
                    last_grant_reg <= owner_reg;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        target_dataslot_read  = 1'b0;
        target_dataslot_write = 1'b0;
        done_vec              = 2'b00;
        active                = (state_reg != S_IDLE);
        if (state_reg == S_ISSUE) begin
            target_dataslot_read  = ~write_sel_reg;
            target_dataslot_write = write_sel_reg;
        end
        if (state_reg == S_COMPLETE) begin
            done_vec[owner_reg] = 1'b1;
        end
    end

    assign owner                      = owner_reg;
    assign target_dataslot_id         = id_reg;
    assign target_dataslot_slotoffset = off_reg;
    assign target_dataslot_bridgeaddr = addr_reg;
    assign target_dataslot_length     = len_reg;

    assign r0_busy = pending[0];
    assign r1_busy = pending[1];
    assign r0_done = done_vec[0];
    assign r1_done = done_vec[1];
    assign r0_err  = err_q[0];
    assign r1_err  = err_q[1];

endmodule

// File: tb/tb_dataslot_cmd_arbiter.sv
// Bench for dataslot_cmd_arbiter: directed scenarios plus random commands, checked against
// completion times and results computed from the command rules with plain arithmetic.
module tb_dataslot_cmd_arbiter;

    localparam int P   = 4;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_req, r0_write, r1_req, r1_write;
    logic [15:0] r0_id, r1_id;
    logic [31:0] r0_slotoffset, r0_bridgeaddr, r0_length;
    logic [31:0] r1_slotoffset, r1_bridgeaddr, r1_length;
    logic        r0_busy, r0_done, r1_busy, r1_done;
    logic [2:0]  r0_err, r1_err;
    logic        t_read, t_write, t_ack, t_done;
    logic [15:0] t_id;
    logic [31:0] t_off, t_addr, t_len;
    logic [2:0]  t_err;
    logic        owner, active;

    dataslot_cmd_arbiter #(.PULSE_CYCLES(P), .TIMEOUT_CYCLES(24'd100)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_write(r0_write), .r0_id(r0_id), .r0_slotoffset(r0_slotoffset),
        .r0_bridgeaddr(r0_bridgeaddr), .r0_length(r0_length),
        .r0_busy(r0_busy), .r0_done(r0_done), .r0_err(r0_err),
        .r1_req(r1_req), .r1_write(r1_write), .r1_id(r1_id), .r1_slotoffset(r1_slotoffset),
        .r1_bridgeaddr(r1_bridgeaddr), .r1_length(r1_length),
        .r1_busy(r1_busy), .r1_done(r1_done), .r1_err(r1_err),
        .target_dataslot_read(t_read), .target_dataslot_write(t_write),
        .target_dataslot_id(t_id), .target_dataslot_slotoffset(t_off),
        .target_dataslot_bridgeaddr(t_addr), .target_dataslot_length(t_len),
        .target_dataslot_ack(t_ack), .target_dataslot_done(t_done), .target_dataslot_err(t_err),
        .owner(owner), .active(active)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc_g    = 0;

    int          model_last;
    logic [2:0]  model_err [2];
    logic [15:0] p_id   [2];
    logic [31:0] p_off  [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_len  [2];

    task automatic step();
        @(posedge clk);
        #1;
        cyc_g++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_g, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " read"}, 64'(t_read), 64'd0);
        chk({tag, " write"}, 64'(t_write), 64'd0);
        chk({tag, " active"}, 64'(active), 64'd0);
        chk({tag, " owner"}, 64'(owner), 64'd0);
        chk({tag, " busy"}, 64'({r1_busy, r0_busy}), 64'd0);
        chk({tag, " done"}, 64'({r1_done, r0_done}), 64'd0);
        chk({tag, " err"}, 64'({r1_err, r0_err}), 64'd0);
        chk({tag, " target"}, 64'(t_id) ^ 64'(t_off) ^ 64'(t_addr) ^ 64'(t_len), 64'd0);
    endtask

    task automatic rand_params();
        for (int i = 0; i < 2; i++) begin
            p_id[i]   = 16'($urandom);
            p_off[i]  = $urandom;
            p_addr[i] = $urandom;
            p_len[i]  = $urandom;
        end
    endtask

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Cycle of the done pulse for a command whose strobe starts at s: ack occupies
    // [s+a, s+a+L) (L=0: never), done is high from s+ds until completion.
    function automatic int exp_f(input int s, input int a, input int L, input int ds, output bit tmo);
        int cst, d;
        if (L == 0) begin
            tmo = 1'b1;
            return s + TMO + 1;
        end
        cst = imax(s + P, s + a + 1);
        d   = imax(cst + 1, imax(s + a + L, s + ds));
        if (d >= s + TMO) begin
            tmo = 1'b1;
            return s + TMO + 1;
        end
        tmo = 1'b0;
        return d + 1;
    endfunction

    task automatic run_cmds(input bit use0, input bit use1, input bit wr0, input bit wr1,
                            input int a, input int L, input int ds,
                            input logic [2:0] e0, input logic [2:0] e1, input bit rereq);
        int n, t0, last_f, k, hit;
        int who [2];
        int s   [2];
        int f   [2];
        logic [2:0] eres [2];
        bit wrq [2];
        logic [2:0] eq [2];
        bit tmo;
        logic exp_rd, exp_wr, exp_act, exp_own;
        logic [1:0] exp_d, exp_b;
        wrq[0] = wr0; wrq[1] = wr1;
        eq[0] = e0;   eq[1] = e1;
        n = int'(use0) + int'(use1);
        if (use0 && use1) begin
            who[0] = (model_last == 1) ? 0 : 1;
            who[1] = 1 - who[0];
        end else begin
            who[0] = use1 ? 1 : 0;
            who[1] = 1 - who[0];
        end
        t0 = cyc_g;
        r0_req = use0; r0_write = wr0; r0_id = p_id[0]; r0_slotoffset = p_off[0];
        r0_bridgeaddr = p_addr[0]; r0_length = p_len[0];
        r1_req = use1; r1_write = wr1; r1_id = p_id[1]; r1_slotoffset = p_off[1];
        r1_bridgeaddr = p_addr[1]; r1_length = p_len[1];
        if (ds < 0) t_done = 1'b1;
        s[0] = t0 + 2;
        f[0] = exp_f(s[0], a, L, ds, tmo);
        eres[0] = tmo ? 3'b111 : eq[who[0]];
        s[1] = f[0] + 2;
        f[1] = exp_f(s[1], a, L, ds, tmo);
        eres[1] = tmo ? 3'b111 : eq[who[1]];
        last_f = f[n-1];
        step();
        for (int c = t0 + 1; c <= last_f + 5; c++) begin
            exp_rd = 1'b0; exp_wr = 1'b0; exp_act = 1'b0; exp_own = 1'b0;
            exp_d = 2'b00; exp_b = 2'b00;
            for (int j = 0; j < n; j++) begin
                if (c >= s[j] && c < s[j] + P) begin
                    if (wrq[who[j]]) exp_wr = 1'b1; else exp_rd = 1'b1;
                end
                if (c >= s[j] && c <= f[j]) begin
                    exp_act = 1'b1;
                    exp_own = who[j][0];
                end
                if (c == f[j]) exp_d[who[j]] = 1'b1;
                if (c <= f[j]) exp_b[who[j]] = 1'b1;
                if (c == s[j]) begin
                    chk("target_id", 64'(t_id), 64'(p_id[who[j]]));
                    chk("target_off", 64'(t_off), 64'(p_off[who[j]]));
                    chk("target_addr", 64'(t_addr), 64'(p_addr[who[j]]));
                    chk("target_len", 64'(t_len), 64'(p_len[who[j]]));
                end
            end
            chk("read_strobe", 64'(t_read), 64'(exp_rd));
            chk("write_strobe", 64'(t_write), 64'(exp_wr));
            chk("active", 64'(active), 64'(exp_act));
            if (exp_act) chk("owner", 64'(owner), 64'(exp_own));
            chk("done_pulses", 64'({r1_done, r0_done}), 64'(exp_d));
            chk("busy", 64'({r1_busy, r0_busy}), 64'(exp_b));
            // responder for the command currently in flight
            k = (n == 2 && c >= f[0] + 1) ? 1 : 0;
            t_ack  = (L > 0) && (c >= s[k] + a) && (c < s[k] + a + L);
            t_done = (c < f[k]) && (c >= s[k] + ds);
            t_err  = eq[who[k]];
            hit = rereq && (c == t0 + 6 || c == f[0]);
            r0_req = hit && who[0] == 0;
            r1_req = hit && who[0] == 1;
            step();
        end
        r0_req = 1'b0; r1_req = 1'b0; t_ack = 1'b0; t_done = 1'b0;
        for (int j = 0; j < n; j++) begin
            model_err[who[j]] = eres[j];
            model_last = who[j];
        end
        chk("r0_err", 64'(r0_err), 64'(model_err[0]));
        chk("r1_err", 64'(r1_err), 64'(model_err[1]));
        $display("cmd t0=%0d use=%0d%0d first=r%0d done_at=%0d err=%0h checks=%0d failures=%0d",
                 t0, use1, use0, who[0], f[0], eres[0], checks, failures);
    endtask

    initial begin
        int t0, a, L, ds, sel;
        reset = 1'b1;
        r0_req = 0; r0_write = 0; r0_id = 0; r0_slotoffset = 0; r0_bridgeaddr = 0; r0_length = 0;
        r1_req = 0; r1_write = 0; r1_id = 0; r1_slotoffset = 0; r1_bridgeaddr = 0; r1_length = 0;
        t_ack = 0; t_done = 0; t_err = 0;
        model_last = 1;
        model_err[0] = 3'b000; model_err[1] = 3'b000;
        step(); step();
        chk_all_zero("in_reset");
        reset = 1'b0;
        step();
        chk_all_zero("after_reset");

        // simultaneous requests alternate, r0 first after reset
        rand_params();
        run_cmds(1, 1, 0, 1, 1, 1, 2, 3'b001, 3'b011, 0);
        rand_params();
        run_cmds(1, 1, 1, 0, 0, 2, 3, 3'b100, 3'b101, 0);

        // single r0 read: ack at strobe+2 for 10 cycles, then done
        rand_params();
        p_id[0] = 16'h0002; p_len[0] = 32'h200;
        run_cmds(1, 0, 0, 0, 2, 10, 12, 3'b000, 3'b000, 0);

        // stale done held from before the strobe; ack arrives 20 cycles later
        rand_params();
        run_cmds(1, 0, 0, 0, 20, 3, -1, 3'b011, 3'b000, 0);

        // no ack at all: timeout
        rand_params();
        run_cmds(0, 1, 0, 0, 0, 0, 10000, 3'b000, 3'b000, 0);

        // write with err=2, extra requests while busy and in COMPLETE are dropped
        rand_params();
        run_cmds(0, 1, 0, 1, 1, 2, 4, 3'b000, 3'b010, 1);

        for (int i = 0; i < 8; i++) begin
            rand_params();
            sel = $urandom_range(1, 3);
            a   = $urandom_range(0, 6);
            L   = $urandom_range(1, 10);
            ds  = $urandom_range(0, a + L + 4);
            run_cmds(sel[0], sel[1], 1'($urandom), 1'($urandom), a, L, ds,
                     3'($urandom), 3'($urandom), 0);
        end

        // reset while waiting for done
        rand_params();
        t0 = cyc_g;
        r0_req = 1'b1; r0_write = 1'b0; r0_id = p_id[0];
        step();
        r0_req = 1'b0;
        for (int c = t0 + 1; c < t0 + 10; c++) begin
            t_ack = (c >= t0 + 2 && c < t0 + 4);
            step();
        end
        t_ack = 1'b0;
        chk("pre_reset active", 64'(active), 64'd1);
        chk("pre_reset busy0", 64'(r0_busy), 64'd1);
        reset = 1'b1;
        step();
        chk_all_zero("mid_cmd_reset");
        reset = 1'b0;
        model_last = 1;
        model_err[0] = 3'b000; model_err[1] = 3'b000;
        for (int c = 0; c < 6; c++) begin
            t_ack  = (c < 3);
            t_done = 1'b1;
            t_err  = 3'b110;
            step();
            chk("late_resp active", 64'(active), 64'd0);
            chk("late_resp done", 64'({r1_done, r0_done}), 64'd0);
            chk("late_resp busy", 64'({r1_busy, r0_busy}), 64'd0);
        end
        t_ack = 1'b0; t_done = 1'b0;
        step();
        $display("mid-command reset absorbed checks=%0d failures=%0d", checks, failures);
        rand_params();
        run_cmds(1, 0, 0, 0, 0, 1, 2, 3'b001, 3'b000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
